data_split: RTL

Byte serializer for the dscope capture path, and the transmit-side counterpart of the byte-to-word packer. It accepts 32-bit words over a valid/ready handshake and emits them as a paced byte stream, MSB first. Each frame of FRAME_WORDS words is preceded by a one-cycle sync strobe, so a downstream packer that clears its byte counter on sync realigns to frame boundaries.

---
 rtl/data_split_pkg.sv | 20 ++
 rtl/data_split_frame_counter.sv | 35 +++
 rtl/data_split.sv | 126 ++++++++++++
 3 files changed

// File: rtl/data_split_pkg.sv
// data_split_pkg: definitions shared by the dscope byte serializer and the
// frame counter. These are also usable on the receive side.
//   state_t        - serializer FSM states
//   BYTES_PER_WORD - bytes emitted per 32-bit word
//   cnt_width()    - width of a modulo-FRAME_WORDS counter (minimum 1 bit)
package data_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic int cnt_width(input int frame_words);
        return (frame_words <= 2) ? 1 : $clog2(frame_words);
    endfunction

endpackage

// File: rtl/data_split_frame_counter.sv
// frame_counter: modulo-FRAME_WORDS word counter.
//   clk, rst - clock, synchronous active-high reset (count returns to 0)
//   i_inc    - advance the count by one, wrapping after FRAME_WORDS-1
//   o_zero   - count is 0 (the next word starts a frame)
//   o_last   - count is FRAME_WORDS-1 (the next increment wraps to 0)
module frame_counter
    import data_split_pkg::*;
#(
    parameter int FRAME_WORDS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    output logic o_zero,
    output logic o_last
);

    localparam int CNT_W = cnt_width(FRAME_WORDS);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(FRAME_WORDS - 1));
    assign o_last = w_last;
    assign o_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/data_split.sv
// data_split: serializes 32-bit words into a paced byte stream, MSB first.
// Each frame of FRAME_WORDS words is preceded by a one-cycle sync strobe.
//   clk, rst   - clock, synchronous active-high reset
//   i_in_data  - word to serialize, [31:24] sent first
//   i_in_vld   - i_in_data valid; transfer when i_in_vld && o_in_rdy
//   o_in_rdy   - block can accept a word (combinational, independent of i_in_vld)
//   i_out_en   - pacing enable, at most one output event per enabled cycle
//   o_data     - output byte (registered), valid while o_wren
//   o_wren     - one-cycle byte strobe
//   o_sync     - one-cycle frame-start strobe, never together with o_wren
//   o_busy     - FSM not idle
module data_split
    import data_split_pkg::*;
#(
    parameter int FRAME_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_in_data,
    input  logic        i_in_vld,
    output logic        o_in_rdy,
    input  logic        i_out_en,
    output logic [7:0]  o_data,
    output logic        o_wren,
    output logic        o_sync,
    output logic        o_busy
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_sh, w_sh_nxt;
    logic [1:0]  r_bcnt, w_bcnt_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_wren, w_wren_nxt;
    logic        r_sync, w_sync_nxt;
    logic        w_rdy;
    logic        w_inc;
    logic        w_frame_zero;
    logic        w_frame_last;

    frame_counter #(
        .FRAME_WORDS (FRAME_WORDS)
    ) u_frame_counter (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_inc),
        .o_zero (w_frame_zero),
        .o_last (w_frame_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_bcnt_nxt  = r_bcnt;
        w_data_nxt  = r_data;
        w_wren_nxt  = 1'b0;
        w_sync_nxt  = 1'b0;
        w_rdy       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rdy = 1'b1;
                if (i_in_vld) begin
                    w_sh_nxt    = i_in_data;
                    w_bcnt_nxt  = 2'd0;
                    w_state_nxt = w_frame_zero ? ST_SYNC : ST_SHIFT;
                end
            end
            ST_SYNC: begin
                // The sync cycle carries no byte: the packer lets sync win
                // over a write arriving in the same cycle.
                if (i_out_en) begin
                    w_sync_nxt  = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_out_en) begin
                    w_data_nxt = r_sh[31:24];
                    w_wren_nxt = 1'b1;
                    w_sh_nxt   = {r_sh[23:0], 8'h00};
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'(BYTES_PER_WORD - 1)) begin
                        // Accepting during the last byte keeps words gapless.
                        w_inc = 1'b1;
                        w_rdy = 1'b1;
                        if (i_in_vld) begin
                            w_sh_nxt    = i_in_data;
                            w_bcnt_nxt  = 2'd0;
                            w_state_nxt = w_frame_last ? ST_SYNC : ST_SHIFT;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sh    <= '0;
            r_bcnt  <= '0;
            r_data  <= '0;
            r_wren  <= 1'b0;
            r_sync  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_data  <= w_data_nxt;
            r_wren  <= w_wren_nxt;
            r_sync  <= w_sync_nxt;
        end
    end

    assign o_in_rdy = w_rdy;
    assign o_data   = r_data;
    assign o_wren   = r_wren;
    assign o_sync   = r_sync;
    assign o_busy   = (r_state != ST_IDLE);

endmodule
